// File: rtl/gray_remap_pkg.sv
// Shared definitions for the grayscale remap path: coordinate word layout,
// block line lengths and the upsampler state encoding.
package gray_remap_pkg;

  localparam int COORD_W       = 34;
  localparam int EOF_BIT       = 33;
  localparam int SHORT_BIT     = 32;
  localparam int BLK_PIX_SHORT = 8;
  localparam int BLK_PIX_FULL  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REPEAT
  } statetype;

  function automatic logic [4:0] line_len(input logic short_line);
    return short_line ? 5'(BLK_PIX_SHORT) : 5'(BLK_PIX_FULL);
  endfunction

endpackage

// File: rtl/gray_upsample_coord_fifo.sv
// Show-ahead single-clock FIFO for half-res coordinate words; the head word
// is readable combinationally whenever the FIFO is non-empty.
module gray_upsample_coord_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gray_upsample.sv
// Read-side 2x2 upsampler: each half-res block line becomes two full-res
// lines with every pixel doubled; the second line is replayed from a buffer.
module gray_upsample
  import gray_remap_pkg::*;
#(
  parameter int fifo_depth = 16,
  parameter int line_max   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [33:0] coords_in,
  input  logic        coords_in_valid,
  output logic        coord_overflow,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic        pixel_in_ready,
  output logic [33:0] coords_out,
  output logic        coords_out_valid,
  output logic [7:0]  pixel_out,
  output logic        pixel_out_valid,
  input  logic        pixel_out_ready
);

  localparam int ADDR_W = $clog2(line_max);

  statetype     state_q;
  logic [4:0]   idx_q;
  logic [1:0]   cnt_q;
  logic [7:0]   pix_q;
  logic         phase_q;
  logic [33:0]  word_q;
  logic         overflow_q;
  logic [7:0]   buf_q [line_max];

  logic [33:0]  head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [4:0]   n_pix;
  logic         in_xfer;
  logic         start_line;
  logic         fill_done;
  logic         unused_pad;

  gray_upsample_coord_fifo #(
    .DEPTH (fifo_depth),
    .W     (COORD_W)
  ) u_coord_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (coords_in_valid),
    .data_i  (coords_in),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bits 31 and 15 of the half-res word are zero padding.
  assign unused_pad = word_q[31] ^ word_q[15];

  assign n_pix          = line_len(word_q[SHORT_BIT]);
  assign pixel_in_ready = (state_q == ST_FILL) && (idx_q < n_pix) &&
                          ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pixel_out_ready));
  assign in_xfer        = pixel_in_ready & pixel_in_valid;
  assign pixel_out_valid = (state_q == ST_REPEAT) || ((state_q == ST_FILL) && (cnt_q != 2'd0));
  assign pixel_out      = (state_q == ST_REPEAT) ? buf_q[idx_q[ADDR_W-1:0]] : pix_q;
  assign start_line     = (state_q == ST_IDLE) && !fifo_empty;
  assign fill_done      = (state_q == ST_FILL) && (idx_q == n_pix) &&
                          (cnt_q == 2'd1) && pixel_out_ready;
  assign fifo_pop         = start_line;
  assign coords_out_valid = start_line | fill_done;
  assign coord_overflow   = overflow_q;

  // Full-res coordinates are the half-res fields shifted left by one bit.
  always_comb begin
    coords_out = '0;
    if (start_line) begin
      coords_out = {1'b0, head[SHORT_BIT], head[30:16], 1'b0, head[14:0], 1'b0};
    end else if (fill_done) begin
      coords_out = {word_q[EOF_BIT], word_q[SHORT_BIT], word_q[30:16], 1'b1,
                    word_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      phase_q    <= 1'b0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (coords_in_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            word_q  <= head;
            idx_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (in_xfer) begin
            pix_q <= pixel_in;
            cnt_q <= 2'd2;
            idx_q <= idx_q + 5'd1;
          end else if ((cnt_q != 2'd0) && pixel_out_ready) begin
            cnt_q <= cnt_q - 2'd1;
          end
          if (fill_done) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
            state_q <= ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          // Each buffered pixel goes out twice; phase marks the second copy.
          if (pixel_out_ready) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              idx_q <= idx_q + 5'd1;
              if (idx_q == n_pix - 5'd1) state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) buf_q[idx_q[ADDR_W-1:0]] <= pixel_in;
  end

endmodule

// File: tb/tb_gray_upsample.sv
// Scoreboard bench for gray_upsample: stimulus queues expected coords and
// pixels, a negedge monitor pops and compares whatever the DUT presents.
module tb_gray_upsample;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [33:0] coords_in;
  logic        coords_in_valid;
  logic        coord_overflow;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        pixel_in_ready;
  logic [33:0] coords_out;
  logic        coords_out_valid;
  logic [7:0]  pixel_out;
  logic        pixel_out_valid;
  logic        pixel_out_ready;

  int vectors     = 0;
  int miscompares = 0;
  int outCount    = 0;
  int repeatLeft  = 0;
  bit feedEn      = 1'b1;
  bit bpEn        = 1'b0;
  bit prevHold    = 1'b0;
  logic [7:0]  prevPix = '0;

  logic [33:0] expCoordQ [$];
  logic [7:0]  expPixQ   [$];
  logic [7:0]  inPixQ    [$];

  always #5 clk = ~clk;

  gray_upsample dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .coords_in        (coords_in),
    .coords_in_valid  (coords_in_valid),
    .coord_overflow   (coord_overflow),
    .pixel_in         (pixel_in),
    .pixel_in_valid   (pixel_in_valid),
    .pixel_in_ready   (pixel_in_ready),
    .coords_out       (coords_out),
    .coords_out_valid (coords_out_valid),
    .pixel_out        (pixel_out),
    .pixel_out_valid  (pixel_out_valid),
    .pixel_out_ready  (pixel_out_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagMissing(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: DUT output with nothing expected at %0t", name, $time);
  endtask

  // Queue one coordinate word; expectIt=0 models a word the FIFO must drop.
  task automatic applyStimulus(input bit eof, input bit sh, input logic [14:0] row,
                               input logic [14:0] col, input logic [7:0] base,
                               input bit expectIt);
    int n;
    logic [7:0] v;
    n = sh ? 8 : 16;
    @(posedge clk); #1;
    coords_in       = {eof, sh, 1'b0, row, 1'b0, col};
    coords_in_valid = 1'b1;
    if (expectIt) begin
      expCoordQ.push_back({1'b0, sh, row, 1'b0, col, 1'b0});
      expCoordQ.push_back({eof, sh, row, 1'b1, col, 1'b0});
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < n; i++) begin
          v = base + 8'(i);
          expPixQ.push_back(v);
          expPixQ.push_back(v);
        end
      end
      for (int i = 0; i < n; i++) begin
        v = base + 8'(i);
        inPixQ.push_back(v);
      end
    end
    @(posedge clk); #1;
    coords_in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    while ((expPixQ.size() > 0 || expCoordQ.size() > 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (expPixQ.size() > 0 || expCoordQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d pixels and %0d coords still pending, required 0",
               expPixQ.size(), expCoordQ.size());
    end
    repeat (4) @(posedge clk);
  endtask

  // Monitor: scoreboard compare, hold stability, and no input acceptance during replay.
  always @(negedge clk) begin
    if (reset_n) begin
      if (repeatLeft > 0) checkOutput("in_ready_in_repeat", 64'(pixel_in_ready), 64'd0);
      if (prevHold && pixel_out_valid) checkOutput("hold_stable", 64'(pixel_out), 64'(prevPix));
      prevHold = pixel_out_valid && !pixel_out_ready;
      prevPix  = pixel_out;
      if (pixel_out_valid && pixel_out_ready) begin
        outCount++;
        if (repeatLeft > 0) repeatLeft--;
        if (expPixQ.size() == 0) flagMissing("unexpected_pixel");
        else checkOutput("pixel", 64'(pixel_out), 64'(expPixQ.pop_front()));
      end
      if (coords_out_valid) begin
        if (expCoordQ.size() == 0) flagMissing("unexpected_coords");
        else checkOutput("coords", 64'(coords_out), 64'(expCoordQ.pop_front()));
        if (coords_out[16]) repeatLeft = coords_out[32] ? 16 : 32;
      end
    end
  end

  // Pixel source: presents the head of inPixQ, retires it once accepted.
  initial begin
    bit took;
    forever begin
      @(negedge clk);
      took = pixel_in_valid && pixel_in_ready && reset_n;
      @(posedge clk); #1;
      if (took && inPixQ.size() > 0) void'(inPixQ.pop_front());
      if (feedEn && inPixQ.size() > 0) begin
        pixel_in_valid = 1'b1;
        pixel_in       = inPixQ[0];
      end else begin
        pixel_in_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pixel_out_ready = bpEn ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int c;
    reset_n         = 1'b0;
    coords_in       = '0;
    coords_in_valid = 1'b0;
    pixel_in        = '0;
    pixel_in_valid  = 1'b0;
    pixel_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_coords_out_valid", 64'(coords_out_valid), 64'd0);
    checkOutput("rst_coords_out", 64'(coords_out), 64'd0);
    checkOutput("rst_pixel_out_valid", 64'(pixel_out_valid), 64'd0);
    checkOutput("rst_pixel_out", 64'(pixel_out), 64'd0);
    checkOutput("rst_pixel_in_ready", 64'(pixel_in_ready), 64'd0);
    checkOutput("rst_coord_overflow", 64'(coord_overflow), 64'd0);
    reset_n = 1'b1;

    $display("[TB] full line");
    applyStimulus(1'b0, 1'b0, 15'd5, 15'd12, 8'h00, 1'b1);
    waitDrain(300);

    $display("[TB] short line with eof");
    applyStimulus(1'b1, 1'b1, 15'd3, 15'd4, 8'hA0, 1'b1);
    waitDrain(300);

    $display("[TB] random backpressure");
    bpEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 15'd5, 15'd12, 8'h00, 1'b1);
    waitDrain(1000);
    bpEn = 1'b0;

    $display("[TB] back-to-back words");
    feedEn = 1'b0;
    applyStimulus(1'b0, 1'b0, 15'd20, 15'd100, 8'h10, 1'b1);
    applyStimulus(1'b0, 1'b1, 15'd21, 15'd101, 8'h30, 1'b1);
    applyStimulus(1'b0, 1'b0, 15'd22, 15'h7FFF, 8'h40, 1'b1);
    applyStimulus(1'b1, 1'b1, 15'h7FFF, 15'd103, 8'hF8, 1'b1);
    repeat (10) @(posedge clk);
    feedEn = 1'b1;
    waitDrain(800);
    checkOutput("b2b_overflow", 64'(coord_overflow), 64'd0);

    // The first word leaves the FIFO at once and parks in fill, so the
    // next 16 fill the FIFO and the 17th push overflows.
    $display("[TB] overflow");
    feedEn = 1'b0;
    applyStimulus(1'b0, 1'b1, 15'd40, 15'd7, 8'h00, 1'b1);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k[0], k[1], 15'(41 + k), 15'(200 + k), 8'(k * 16), 1'b1);
    end
    checkOutput("ovf_before_17th", 64'(coord_overflow), 64'd0);
    applyStimulus(1'b0, 1'b0, 15'd99, 15'd99, 8'h77, 1'b0);
    checkOutput("ovf_after_17th", 64'(coord_overflow), 64'd1);
    feedEn = 1'b1;
    waitDrain(2500);
    checkOutput("ovf_sticky", 64'(coord_overflow), 64'd1);

    $display("[TB] reset mid-line");
    applyStimulus(1'b0, 1'b0, 15'd7, 15'd9, 8'h50, 1'b1);
    start = outCount;
    c = 0;
    while (outCount < start + 5 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    checkOutput("reset_wait_pixels", 64'(outCount - start), 64'd5);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_coords_out_valid", 64'(coords_out_valid), 64'd0);
    checkOutput("mid_rst_coords_out", 64'(coords_out), 64'd0);
    checkOutput("mid_rst_pixel_out_valid", 64'(pixel_out_valid), 64'd0);
    checkOutput("mid_rst_pixel_out", 64'(pixel_out), 64'd0);
    checkOutput("mid_rst_pixel_in_ready", 64'(pixel_in_ready), 64'd0);
    checkOutput("mid_rst_coord_overflow", 64'(coord_overflow), 64'd0);
    expPixQ.delete();
    expCoordQ.delete();
    inPixQ.delete();
    prevHold   = 1'b0;
    repeatLeft = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 15'd2, 15'd2, 8'hC0, 1'b1);
    waitDrain(300);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
